word_serializer: RTL

Byte-serialiser stage that sits directly upstream of the 16:1 byte mux and also consumes its output. It accepts one 128-bit word over a valid/ready handshake and holds it on the mux data input. It steps the 4-bit mux select from 0 to 15 and presents each selected byte on a valid/ready byte stream toward the UART TX path. Byte 0 (bits 7:0) goes first.

---
 rtl/word_serializer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/word_serializer.sv
// word_serializer: accepts one 128-bit word and streams its 16 bytes (byte 0
// first) toward the UART TX path. The held word drives an external 16:1 byte
// mux. The selected byte comes back on mux_out and is forwarded on byte_out.
//
// Handshake semantics (both interfaces): a transfer happens on a rising edge
// where valid && ready are both high. A source keeps valid and its data stable
// until that edge. A sink may hold ready low for any number of cycles.
// word_ready is high only in IDLE. byte_valid is high only in SEND.
module word_serializer #(
  parameter int IDLE_GAP = 0,
  parameter int GAP_W    = 8
) (
  input  logic         clk,
  input  logic         nRst,
  input  logic [127:0] word_in,
  input  logic         word_valid,
  output logic         word_ready,
  input  logic         abort,
  output logic [127:0] mux_in,
  output logic [3:0]   mux_sel,
  input  logic [7:0]   mux_out,
  output logic [7:0]   byte_out,
  output logic         byte_valid,
  input  logic         byte_ready,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  // Gap counter start value; the GAP state lasts exactly IDLE_GAP cycles.
  localparam logic [GAP_W-1:0] GAP_LOAD =
    (IDLE_GAP > 0) ? GAP_W'(IDLE_GAP - 1) : '0;
  localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);

  state_t             state, state_n;
  logic [127:0]       hold_q, hold_n;
  logic [3:0]         sel_q, sel_n;
  logic [GAP_W-1:0]   gap_q, gap_n;
  logic               done_q, done_n;
  logic               byte_hs;

  assign byte_hs = byte_valid && byte_ready;

  // State and datapath registers. Reset returns everything to idle at once.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state  <= S_IDLE;
      hold_q <= '0;
      sel_q  <= '0;
      gap_q  <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      hold_q <= hold_n;
      sel_q  <= sel_n;
      gap_q  <= gap_n;
      done_q <= done_n;
    end
  end

  // Next-state logic. Abort wins over a simultaneous byte handshake.
  always_comb begin
    state_n = state;
    hold_n  = hold_q;
    sel_n   = sel_q;
    gap_n   = gap_q;
    done_n  = 1'b0;
    case (state)
      S_IDLE: begin
        if (word_valid) begin
          hold_n  = word_in;
          sel_n   = 4'd0;
          state_n = S_SEND;
        end
      end
      S_SEND: begin
        if (abort) begin
          sel_n   = 4'd0;
          state_n = S_IDLE;
        end else if (byte_hs) begin
          if (sel_q == 4'd15) begin
            sel_n   = 4'd0;
            done_n  = 1'b1;
            state_n = S_IDLE;
          end else begin
            sel_n = sel_q + 4'd1;
            if (IDLE_GAP > 0) begin
              gap_n   = GAP_LOAD;
              state_n = S_GAP;
            end
          end
        end
      end
      S_GAP: begin
        if (abort) begin
          sel_n   = 4'd0;
          state_n = S_IDLE;
        end else if (gap_q == '0) begin
          state_n = S_SEND;
        end else begin
          gap_n = gap_q - GAP_ONE;
        end
      end
      default: begin
        sel_n   = 4'd0;
        state_n = S_IDLE;
      end
    endcase
  end

  // Handshake flags decode directly from state. Data comes from the hold register and the mux.
  always_comb begin
    word_ready = (state == S_IDLE);
    byte_valid = (state == S_SEND);
    busy       = (state != S_IDLE);
    mux_in     = hold_q;
    mux_sel    = sel_q;
    byte_out   = mux_out;
    done       = done_q;
  end

endmodule
